complex_sub_arbiter: RTL and testbench

// - Shares one complex subtract pipeline among NREQ requesters using round-robin arbitration.
// - Drives the shared unit's in_valid/a/b ports and tracks each request's id through the unit's fixed latency.
// - Returns every result tagged with the requester id; a drain sequence quiesces the unit before reconfiguration.

---
 rtl/complex_sub_arbiter.sv | 119 +++++++++++
 tb/tb_complex_sub_arbiter.sv | 245 ++++++++++++++++++++++++
 2 files changed

// File: rtl/complex_sub_arbiter.sv
// complex_sub_arbiter: round-robin sharing of one complex subtract unit with id tagging and drain.
// Define COMPLEX_SUB_ARB_TAGCHK_EN to add the sticky tag_err lost/spurious-result flag.
module complex_sub_arbiter #(
    parameter int BITS      = 16,
    parameter     PRECISION = "COMPLEX",
    parameter int NREQ      = 4,
    parameter int LATENCY   = 2,
    parameter int IDW       = (NREQ > 1) ? $clog2(NREQ) : 1
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [NREQ-1:0]      req_valid,
    output logic [NREQ-1:0]      req_ready,
    input  logic [NREQ*BITS-1:0] req_a,
    input  logic [NREQ*BITS-1:0] req_b,
    output logic                 sub_in_valid,
    output logic [BITS-1:0]      sub_a,
    output logic [BITS-1:0]      sub_b,
    input  logic                 sub_out_valid,
    input  logic [BITS-1:0]      sub_c,
    output logic                 out_valid,
    output logic [IDW-1:0]       out_id,
    output logic [BITS-1:0]      out_c,
    input  logic                 drain_req,
    output logic                 drain_done,
    output logic                 busy
`ifdef COMPLEX_SUB_ARB_TAGCHK_EN
    ,
    output logic                 tag_err
`endif
);
    localparam int BW = $clog2(LATENCY + 1);

    typedef enum logic [1:0] {IDLE, RUN, DRAIN, DRAINED} state_t;

    state_t           state, state_nx;
    logic [IDW-1:0]   ptr, gid;
    logic             gnt;
    logic [BITS-1:0]  ga, gb, last_a, last_b;
    logic [LATENCY-1:0] tv;
    logic [IDW-1:0]   tid [LATENCY];
    logic [BW-1:0]    blank;
    int               j;

    always_comb begin
        gnt = 1'b0;
        gid = '0;
        ga  = last_a;
        gb  = last_b;
        j   = 0;
        for (int k = 0; k < NREQ; k++) begin
            j = (int'(ptr) + k) % NREQ;
            if (!gnt && state == RUN && req_valid[j]) begin
                gnt = 1'b1;
                gid = IDW'(j);
                ga  = req_a[j*BITS +: BITS];
                gb  = req_b[j*BITS +: BITS];
            end
        end
    end

    assign req_ready    = gnt ? (NREQ'(1) << gid) : '0;
    assign sub_in_valid = gnt;
    assign sub_a        = ga;
    assign sub_b        = gb;
    assign busy         = |tv;
    assign drain_done   = state == DRAINED;

    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    state_nx = RUN;
            RUN:     state_nx = drain_req ? DRAIN : RUN;
            DRAIN:   state_nx = !drain_req ? RUN : (busy ? DRAIN : DRAINED);
            DRAINED: state_nx = drain_req ? DRAINED : RUN;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            ptr       <= '0;
            tv        <= '0;
            for (int k = 0; k < LATENCY; k++) tid[k] <= '0;
            out_valid <= 1'b0;
            out_id    <= '0;
            out_c     <= '0;
            last_a    <= '0;
            last_b    <= '0;
            blank     <= BW'(LATENCY);
`ifdef COMPLEX_SUB_ARB_TAGCHK_EN
            tag_err   <= 1'b0;
`endif
        end else begin
            state <= state_nx;
            if (gnt) begin
                ptr    <= (gid == IDW'(NREQ - 1)) ? '0 : gid + 1'b1;
                last_a <= ga;
                last_b <= gb;
            end
            tv[0]  <= gnt;
            tid[0] <= gid;
            for (int k = 1; k < LATENCY; k++) begin
                tv[k]  <= tv[k-1];
                tid[k] <= tid[k-1];
            end
            // results without a matching tail tag are dropped here
            out_valid <= sub_out_valid && tv[LATENCY-1];
            if (sub_out_valid && tv[LATENCY-1]) begin
                out_id <= tid[LATENCY-1];
                out_c  <= sub_c;
            end
            if (blank != '0) blank <= blank - 1'b1;
`ifdef COMPLEX_SUB_ARB_TAGCHK_EN
            if (blank == '0 && sub_out_valid != tv[LATENCY-1]) tag_err <= 1'b1;
`endif
        end
    end
endmodule

// File: tb/tb_complex_sub_arbiter.sv
// tb_complex_sub_arbiter: table vectors, directed sequences and random traffic against a queue model.
module tb_complex_sub_arbiter;
    localparam int BITS = 16, NREQ = 4, LAT = 2, IDW = 2;

    logic clk = 0;
    always #5 clk = ~clk;

    logic rst = 1;
    logic [NREQ-1:0] req_valid = '0, req_ready;
    logic [NREQ*BITS-1:0] req_a = '0, req_b = '0;
    logic sub_in_valid, sub_out_valid, out_valid, drain_req = 0, drain_done, busy;
    logic [BITS-1:0] sub_a, sub_b, sub_c, out_c;
    logic [IDW-1:0] out_id;
    logic force_ov = 0;
`ifdef COMPLEX_SUB_ARB_TAGCHK_EN
    logic tag_err;
`endif

    complex_sub_arbiter #(.BITS(BITS), .PRECISION("COMPLEX"), .NREQ(NREQ), .LATENCY(LAT)) dut (
        .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready),
        .req_a(req_a), .req_b(req_b), .sub_in_valid(sub_in_valid), .sub_a(sub_a), .sub_b(sub_b),
        .sub_out_valid(sub_out_valid), .sub_c(sub_c), .out_valid(out_valid), .out_id(out_id),
        .out_c(out_c), .drain_req(drain_req), .drain_done(drain_done),
`ifdef COMPLEX_SUB_ARB_TAGCHK_EN
        .tag_err(tag_err),
`endif
        .busy(busy));

    function automatic logic [BITS-1:0] csub(input logic [BITS-1:0] a, input logic [BITS-1:0] b);
        logic [7:0] re, im;
        re = a[15:8] - b[15:8];
        im = a[7:0] - b[7:0];
        return {re, im};
    endfunction

    // shared unit: fixed-latency complex subtract, not reset
    logic [LAT-1:0] uv = '0;
    logic [BITS-1:0] uc [LAT];
    always @(posedge clk) begin
        uv[0] <= sub_in_valid;
        uc[0] <= csub(sub_a, sub_b);
        for (int k = 1; k < LAT; k++) begin
            uv[k] <= uv[k-1];
            uc[k] <= uc[k-1];
        end
    end
    assign sub_out_valid = uv[LAT-1] | force_ov;
    assign sub_c = uc[LAT-1];

    typedef struct {int due; int id; logic [BITS-1:0] c;} pend_t;
    pend_t pq[$];
    int mptr = 0, mst = 0, cyc = 0, mblank = LAT;
    logic [BITS-1:0] mla = 0, mlb = 0;
    logic mterr = 0;
    int tests = 0, fails = 0;
    logic [NREQ-1:0] s_rdy;
    logic s_ov, s_done = 0;
    logic [IDW-1:0] s_id;
    logic [BITS-1:0] s_c;

    task automatic chk(input string n, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s cyc=%0d actual=%h required=%h", n, cyc, act, exp);
        end
    endtask

    task automatic step;
        int g;
        logic ebusy, etail, eov;
        int eid;
        logic [BITS-1:0] ec, ea, eb;
        @(negedge clk);
        g = -1;
        if (mst == 1)
            for (int k = 0; k < NREQ; k++)
                if (g < 0 && req_valid[(mptr + k) % NREQ]) g = (mptr + k) % NREQ;
        ebusy = 0; etail = 0; eov = 0; eid = 0; ec = 0;
        foreach (pq[i]) begin
            if (pq[i].due == cyc) begin eov = 1; eid = pq[i].id; ec = pq[i].c; end
            if (pq[i].due > cyc && pq[i].due <= cyc + LAT) ebusy = 1;
            if (pq[i].due == cyc + 1) etail = 1;
        end
        ea = mla; eb = mlb;
        if (g >= 0) begin ea = req_a[g*BITS +: BITS]; eb = req_b[g*BITS +: BITS]; end
        s_rdy = req_ready; s_ov = out_valid; s_id = out_id; s_c = out_c; s_done = drain_done;
        chk("req_ready", 32'(req_ready), g < 0 ? 0 : 32'(1) << g);
        chk("sub_in_valid", 32'(sub_in_valid), 32'(g >= 0));
        chk("sub_a", 32'(sub_a), 32'(ea));
        chk("sub_b", 32'(sub_b), 32'(eb));
        chk("out_valid", 32'(out_valid), 32'(eov));
        if (eov) begin
            chk("out_id", 32'(out_id), 32'(eid));
            chk("out_c", 32'(out_c), 32'(ec));
        end
        chk("busy", 32'(busy), 32'(ebusy));
        chk("drain_done", 32'(drain_done), 32'(mst == 3));
`ifdef COMPLEX_SUB_ARB_TAGCHK_EN
        chk("tag_err_model", 32'(tag_err), 32'(mterr));
`endif
        if (mblank == 0 && force_ov && !etail) mterr = 1;
        if (g >= 0) begin
            pq.push_back('{cyc + LAT + 1, g, csub(ea, eb)});
            mptr = (g + 1) % NREQ;
            mla = ea; mlb = eb;
        end
        case (mst)
            0: mst = 1;
            1: if (drain_req) mst = 2;
            2: mst = !drain_req ? 1 : (ebusy ? 2 : 3);
            default: if (!drain_req) mst = 1;
        endcase
        if (mblank > 0) mblank--;
        while (pq.size() > 0 && pq[0].due <= cyc) void'(pq.pop_front());
        cyc++;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset;
        rst = 1;
        @(posedge clk);
        @(posedge clk);
        #1;
        rst = 0;
        pq.delete();
        mptr = 0; mst = 0; mblank = LAT; mla = 0; mlb = 0; mterr = 0;
    endtask

    typedef struct {logic [NREQ-1:0] v; logic [BITS-1:0] a, b, c; logic [NREQ-1:0] rdy; int id;} vec_t;
    vec_t tbl[6];

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "timeout");
    end

    initial begin
        int n, sp;
        tbl[0] = '{4'b0100, 16'h0503, 16'h0201, 16'h0302, 4'b0100, 2};
        tbl[1] = '{4'b0001, 16'h0000, 16'h0101, 16'hFFFF, 4'b0001, 0};
        tbl[2] = '{4'b0010, 16'h8000, 16'h0100, 16'h7F00, 4'b0010, 1};
        tbl[3] = '{4'b1000, 16'h1234, 16'h1234, 16'h0000, 4'b1000, 3};
        tbl[4] = '{4'b1000, 16'h00FF, 16'h0001, 16'h00FE, 4'b1000, 3};
        tbl[5] = '{4'b0001, 16'h0500, 16'h0001, 16'h05FF, 4'b0001, 0};

        do_reset;
        step;
        chk("reset_outs", {out_valid, out_id, out_c, sub_in_valid, busy, drain_done}, 0);
        step;

        foreach (tbl[i]) begin
            req_valid = tbl[i].v;
            req_a = {NREQ{tbl[i].a}};
            req_b = {NREQ{tbl[i].b}};
            step;
            chk("tbl_ready", 32'(s_rdy), 32'(tbl[i].rdy));
            req_valid = '0;
            repeat (3) step;
            chk("tbl_out_valid", 32'(s_ov), 1);
            chk("tbl_out_id", 32'(s_id), 32'(tbl[i].id));
            chk("tbl_out_c", 32'(s_c), 32'(tbl[i].c));
        end

        do_reset;
        req_valid = 4'hF;
        req_a = {$urandom, $urandom};
        req_b = {$urandom, $urandom};
        step;
        for (int k = 0; k < 8; k++) begin
            step;
            chk("rr_order", 32'(s_rdy), 32'(1) << (k % 4));
        end
        req_valid = '0;
        repeat (4) step;

        req_valid = 4'hF;
        repeat (2) step;
        drain_req = 1;
        step;
        n = 0;
        while (n < LAT + 2 && !s_done) begin
            step;
            if (!s_done) chk("drain_nogrant", 32'(s_rdy), 0);
            n++;
        end
        chk("drain_reached", 32'(s_done), 1);
        sp = mptr;
        drain_req = 0;
        step;
        step;
        chk("resume_ptr", 32'(s_rdy), 32'(1) << sp);

        repeat (2) step;
        req_valid = '0;
        do_reset;
        for (int k = 0; k < 4; k++) begin
            step;
            chk("rst_no_out", 32'(s_ov), 0);
        end
        req_valid = 4'b0110;
        step;
        chk("rst_first_grant", 32'(s_rdy), 32'(4'b0010));

        req_valid = 4'b1000;
        for (int k = 0; k < 5; k++) begin
            req_a = {$urandom, $urandom};
            req_b = {$urandom, $urandom};
            step;
            chk("sole3", 32'(s_rdy), 32'(4'b1000));
        end
        req_valid = '0;
        repeat (4) step;

        for (int k = 0; k < 400; k++) begin
            req_valid = NREQ'($urandom);
            req_a = {$urandom, $urandom};
            req_b = {$urandom, $urandom};
            if ($urandom_range(0, 15) == 0) drain_req = ~drain_req;
            step;
        end
        drain_req = 0;
        req_valid = '0;
        repeat (5) step;

`ifdef COMPLEX_SUB_ARB_TAGCHK_EN
        do_reset;
        repeat (4) step;
        force_ov = 1;
        step;
        force_ov = 0;
        chk("tag_err_set", 32'(tag_err), 1);
        repeat (3) step;
        chk("tag_err_sticky", 32'(tag_err), 1);
        do_reset;
        step;
        chk("tag_err_clear", 32'(tag_err), 0);
`endif

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
